// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// adder_pkg : shared nibble width, nibble type and controller state encoding
//             for nibble_serial_add_ctrl.
// Revision  : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// nibble_serial_add_ctrl_if : start/done request bus between a requesting unit
//                             and the serial adder. SUB_MODE_EN adds sub_i.
// Revision                  : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
);

  localparam int c_w = NIBBLE_W * NIBBLES;

  logic           start_i;
  logic [c_w-1:0] a_i;
  logic [c_w-1:0] b_i;
  logic           cin_i;
`ifdef SUB_MODE_EN
  logic           sub_i;
`endif
  logic           busy_o;
  logic           done_o;
  logic [c_w-1:0] sum_o;
  logic           cout_o;

`ifdef SUB_MODE_EN
  modport master (
    output start_i, a_i, b_i, cin_i, sub_i,
    input  busy_o, done_o, sum_o, cout_o
  );
  modport slave (
    input  start_i, a_i, b_i, cin_i, sub_i,
    output busy_o, done_o, sum_o, cout_o
  );
`else
  modport master (
    output start_i, a_i, b_i, cin_i,
    input  busy_o, done_o, sum_o, cout_o
  );
  modport slave (
    input  start_i, a_i, b_i, cin_i,
    output busy_o, done_o, sum_o, cout_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_cpa4_slice.sv
`default_nettype none
// ============================================================================
// cpa4_slice : combinational 4-bit carry-propagate adder, each bit built from
//              two half adders.
// Revision   : 1.0 - initial release
// ============================================================================
module cpa4_slice
  import adder_pkg::*;
(
  input  wire nibble_t i_a,
  input  wire nibble_t i_b,
  input  wire logic    i_ci,
  output nibble_t      o_s,
  output logic         o_co
);

  wire [NIBBLE_W-1:0] w_s;
  wire [NIBBLE_W:0]   w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    wire w_p;
    wire w_g_ab;
    wire w_g_pc;
    assign w_p      = i_a[i] ^ i_b[i];
    assign w_g_ab   = i_a[i] & i_b[i];
    assign w_s[i]   = w_p ^ w_c[i];
    assign w_g_pc   = w_p & w_c[i];
    assign w_c[i+1] = w_g_ab | w_g_pc;
  end

  assign o_s  = w_s;
  assign o_co = w_c[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_serial_add_ctrl : adds two NIBBLES-wide operands one nibble per clock
//                          through a single cpa4_slice, LSB nibble first.
//                          Define SUB_MODE_EN to add the sub_i (A-B) option.
// Revision               : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
)
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int c_w     = NIBBLE_W * NIBBLES;
  localparam int c_idx_w = $clog2(NIBBLES);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(NIBBLES - 1);

  ctrl_state_t          r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_carry;
  logic [c_w-1:0]       r_a;
  logic [c_w-1:0]       r_b;
  logic [c_w-1:0]       r_shadow;
  logic [c_w-1:0]       r_sum;
  logic                 r_cout;
  logic                 r_busy;
  logic                 r_done;
`ifdef SUB_MODE_EN
  logic                 r_sub;
`endif

  logic [c_idx_w+1:0]   w_base;
  nibble_t              w_a_nib;
  nibble_t              w_b_nib;
  nibble_t              w_s;
  logic                 w_co;
  logic                 w_init_carry;
  logic [c_w-1:0]       w_shadow_next;

  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: NIBBLE_W];

`ifdef SUB_MODE_EN
  // Subtraction is A + ~B + 1; the +1 comes from forcing the initial carry.
  assign w_b_nib      = r_b[w_base +: NIBBLE_W] ^ {NIBBLE_W{r_sub}};
  assign w_init_carry = bus.sub_i ? 1'b1 : bus.cin_i;
`else
  assign w_b_nib      = r_b[w_base +: NIBBLE_W];
  assign w_init_carry = bus.cin_i;
`endif

  cpa4_slice u_slice (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // Shadow with the current nibble merged in, so the final nibble can go
  // straight to sum_o on the completion edge.
  always_comb begin
    w_shadow_next                     = r_shadow;
    w_shadow_next[w_base +: NIBBLE_W] = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SUB_MODE_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start_i) begin
            r_a     <= bus.a_i;
            r_b     <= bus.b_i;
            r_carry <= w_init_carry;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef SUB_MODE_EN
            r_sub   <= bus.sub_i;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_shadow <= w_shadow_next;
          r_carry  <= w_co;
          if (r_idx == c_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_shadow_next;
            r_cout  <= w_co;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
  assign bus.sum_o  = r_sum;
  assign bus.cout_o = r_cout;

endmodule
`default_nettype wire
